// File: rtl/axi_sram_slave_if.sv
// AXI-lite style channel bundle between a memory master and axi_sram_slave.
// Carries AR/R read channels and AW/W/B write channels; master and slave modports.
interface axi_sram_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Word-addressed SRAM behind an AXI-lite style slave port: one read and one write
// in flight at a time each, byte-strobe writes, programmable read latency.
// Ports: clk, rst (sync, active-high), bus (axi_sram_slave_if.slave).
// Optional: define AXI_SRAM_RAND_WAIT_EN for LFSR-driven random back-pressure.
module axi_sram_slave #(
    parameter int          ADDR_BITS    = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          READ_LATENCY = 1
) (
    input logic             clk,
    input logic             rst,
    axi_sram_slave_if.slave bus
);

    localparam int unsigned WORDS  = 1 << ADDR_BITS;
    localparam logic [32:0] SPAN   = 33'd4 << ADDR_BITS;
    localparam logic [4:0]  LAT_M1 = 5'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_COMMIT,
        W_RESP
    } w_state_t;

    logic [31:0] mem [WORDS];

    // 33-bit offset: a borrow sets bit 32, so addresses below the base never
    // alias into the array, and addresses above the top cannot wrap.
    function automatic logic [32:0] offset(input logic [31:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic hit(input logic [31:0] a);
        return offset(a) < SPAN;
    endfunction

    function automatic logic [ADDR_BITS-1:0] widx(input logic [31:0] a);
        return ADDR_BITS'(offset(a) >> 2);
    endfunction

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic [4:0]  rd_cnt;
    logic [4:0]  rd_load;
    logic [31:0] ar_addr;
    logic [31:0] rd_addr;
    logic [31:0] rd_val;
    logic [31:0] rdata_q;
    logic        rd_sample;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [1:0]  bresp_q;
    logic        commit;
    logic        ready_en;
    logic        ar_ok, aw_ok, w_ok;
    logic        ar_hs, aw_hs, w_hs;
    logic        ar_gate, w_gate;
    logic [1:0]  extra;

`ifdef AXI_SRAM_RAND_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign ar_gate = lfsr[0];
    assign w_gate  = lfsr[1];
    assign extra   = lfsr[3:2];
`else
    assign ar_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign extra   = 2'd0;
`endif

    // Readies stay low for the cycle following a reset edge.
    always_ff @(posedge clk) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_comb begin
        ar_ok = (r_state == R_IDLE) && ready_en && ar_gate;
        aw_ok = ((w_state == W_IDLE) || (w_state == W_HAVE_D))
                && ready_en && w_gate;
        w_ok  = ((w_state == W_IDLE) || (w_state == W_HAVE_A))
                && ready_en && w_gate;
    end

    assign ar_hs   = bus.arvalid && ar_ok;
    assign aw_hs   = bus.awvalid && aw_ok;
    assign w_hs    = bus.wvalid && w_ok;
    assign rd_load = LAT_M1 + 5'(extra);

    assign bus.arready = ar_ok;
    assign bus.awready = aw_ok;
    assign bus.wready  = w_ok;
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

    // Read FSM
    always_comb begin
        r_next    = r_state;
        rd_sample = 1'b0;
        rd_addr   = ar_addr;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_addr = bus.araddr;
                    if (rd_load == 5'd0) begin
                        r_next    = R_RESP;
                        rd_sample = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt == 5'd1) begin
                    r_next    = R_RESP;
                    rd_sample = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'd0;
        if (hit(rd_addr)) rd_val = mem[widx(rd_addr)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rd_cnt  <= 5'd0;
            ar_addr <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                ar_addr <= bus.araddr;
                rd_cnt  <= rd_load;
            end else if (r_state == R_WAIT) begin
                rd_cnt <= rd_cnt - 5'd1;
            end
            // Nonblocking sample: a same-edge commit is not yet visible.
            if (rd_sample) rdata_q <= rd_val;
        end
    end

    // Write FSM
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: begin
                if (w_hs) w_next = W_COMMIT;
            end
            W_HAVE_D: begin
                if (aw_hs) w_next = W_COMMIT;
            end
            W_COMMIT: begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: begin
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_addr <= 32'd0;
            w_data  <= 32'd0;
            w_strb  <= 4'd0;
            bresp_q <= 2'b00;
        end else begin
            w_state <= w_next;
            if (aw_hs) aw_addr <= bus.awaddr;
            if (w_hs) begin
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            if (commit) bresp_q <= hit(aw_addr) ? 2'b00 : 2'b10;
        end
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && !rst && hit(aw_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[widx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (READ_LATENCY=3, ADDR_BITS=16).
// Inputs driven and outputs sampled on the falling edge.
module tb_axi_sram_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .ADDR_BITS    (16),
        .BASE_ADDR    (32'h8000_0000),
        .READ_LATENCY (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp);
        logic aw_done, w_done;
        int n;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready) w_done = 1'b1;
            @(negedge clk);
            n++;
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
        end
        while (!bus.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        resp = bus.bresp;
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL wr_timeout addr=%h cycles=%0d limit=50", a, n);
        end
        @(negedge clk);
        bus.bready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output int lat);
        int n;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = bus.rdata;
        checks++;
        if (n >= 50 || lat >= 50) begin
            errors++;
            $display("FAIL rd_timeout addr=%h ar_wait=%0d lat=%0d limit=50",
                     a, n, lat);
        end
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rvalid, bus.bvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valids got=%b exp=00", {bus.rvalid, bus.bvalid});
        end
        checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies got=%b exp=000",
                     {bus.arready, bus.awready, bus.wready});
        end
        checks++;
        if (bus.rdata !== 32'd0 || bus.bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data rdata=%h bresp=%b exp=0/00",
                     bus.rdata, bus.bresp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_readies got=%b exp=111",
                     {bus.arready, bus.awready, bus.wready});
        end
    endtask

    task automatic test_read_latency();
        logic [1:0] resp;
        logic [31:0] d;
        int lat;
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL lat_bresp got=%b exp=00", resp);
        end
        checks++;
        if (bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL lat_arready got=%b exp=1", bus.arready);
        end
        rd(32'h8000_0010, d, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL lat_cycles got=%0d exp=3", lat);
        end
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lat_rdata got=%h exp=deadbeef", d);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] resp;
        logic [31:0] d;
        int lat;
        wr(32'h8000_0020, 32'h1122_3344, 4'hF, resp);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp);
        rd(32'h8000_0020, d, lat);
        checks++;
        if (d !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_rdata got=%h exp=11bb33dd", d);
        end
        wr(32'h8000_0020, 32'h0000_0000, 4'h0, resp);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL strobe0_bresp got=%b exp=00", resp);
        end
        rd(32'h8000_0020, d, lat);
        checks++;
        if (d !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe0_rdata got=%h exp=11bb33dd", d);
        end
    endtask

    task automatic test_write_order();
        logic [31:0] d;
        int lat;
        bus.bready = 1'b0;
        bus.wdata  = 32'h1234_5678;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        checks++;
        if (bus.wready !== 1'b1) begin
            errors++;
            $display("FAIL order_wready got=%b exp=1", bus.wready);
        end
        @(negedge clk);
        bus.wvalid = 1'b0;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid} !== 3'b100) begin
            errors++;
            $display("FAIL order_have_d got=%b exp=100",
                     {bus.awready, bus.wready, bus.bvalid});
        end
        @(negedge clk);
        bus.awaddr  = 32'h8000_0030;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL order_commit got=%b exp=000",
                     {bus.awready, bus.wready, bus.bvalid});
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
                errors++;
                $display("FAIL order_bhold cyc=%0d bvalid=%b bresp=%b exp=1/00",
                         i, bus.bvalid, bus.bresp);
            end
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL order_bdone got=%b exp=0", bus.bvalid);
        end
        rd(32'h8000_0030, d, lat);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL order_rdata got=%h exp=12345678", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [31:0] d;
        int lat;
        wr(32'h8000_0000, 32'hCAFE_F00D, 4'hF, resp);
        wr(32'h8003_FFFC, 32'h0BAD_CAFE, 4'hF, resp);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL oor_top_bresp got=%b exp=00", resp);
        end
        rd(32'h7FFF_FFFC, d, lat);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL oor_rd_low got=%h exp=00000000", d);
        end
        wr(32'h8004_0000, 32'hFFFF_FFFF, 4'hF, resp);
        checks++;
        if (resp !== 2'b10) begin
            errors++;
            $display("FAIL oor_wr_bresp got=%b exp=10", resp);
        end
        rd(32'h8000_0000, d, lat);
        checks++;
        if (d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL oor_word0 got=%h exp=cafef00d", d);
        end
        rd(32'h8003_FFFC, d, lat);
        checks++;
        if (d !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL oor_top_word got=%h exp=0badcafe", d);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp;
        logic [31:0] d;
        int lat, n;
        wr(32'h8000_0040, 32'h0101_0101, 4'hF, resp);
        bus.araddr  = 32'h8000_0040;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.awaddr  = 32'h8000_0040;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0202_0202;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20 || bus.rdata !== 32'h0101_0101) begin
            errors++;
            $display("FAIL coll_old got=%h exp=01010101 wait=%0d", bus.rdata, n);
        end
        n = 0;
        while (!bus.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20 || bus.bresp !== 2'b00) begin
            errors++;
            $display("FAIL coll_bresp got=%b exp=00 wait=%0d", bus.bresp, n);
        end
        @(negedge clk);
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        rd(32'h8000_0040, d, lat);
        checks++;
        if (d !== 32'h0202_0202) begin
            errors++;
            $display("FAIL coll_new got=%h exp=02020202", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        logic [31:0] d;
        int lat;
        wr(32'h8000_0050, 32'h55AA_55AA, 4'hF, resp);
        bus.araddr  = 32'h8000_0050;
        bus.arvalid = 1'b1;
        bus.awaddr  = 32'h8000_0050;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hFFFF_FFFF;
        bus.wstrb   = 4'hF;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_pre_state got=%b exp=001",
                     {bus.arready, bus.awready, bus.wready});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready}
            !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=00000",
                     {bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready});
        end
        @(negedge clk);
        checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
            errors++;
            $display("FAIL mid_release got=%b exp=111",
                     {bus.arready, bus.awready, bus.wready});
        end
        rd(32'h8000_0050, d, lat);
        checks++;
        if (d !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL mid_word got=%h exp=55aa55aa", d);
        end
    endtask

    initial begin
        bus.araddr  = 32'd0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = 32'd0;
        bus.awvalid = 1'b0;
        bus.wdata   = 32'd0;
        bus.wstrb   = 4'd0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        test_reset();
        test_read_latency();
        test_strobes();
        test_write_order();
        test_out_of_range();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI-lite style memory responder on the memory side of the CPU-to-memory path. Sits behind the instruction/data arbiter.
- Serves one read and one write transaction concurrently, each with at most one outstanding.
- Backed by a word-addressed SRAM array with byte-strobe writes and a programmable read latency.
- Used as the simulation main memory.

Parameters:
- ADDR_BITS, 16, log2 of the number of 32-bit words in the array (default 64K words = 256 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LATENCY, 1, cycles from AR handshake to rvalid; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- araddr  input  32  read byte address.
- arvalid  input  1  read address valid.
- arready  output  1  read address accepted.
- rdata  output  32  read data.
- rvalid  output  1  read data valid.
- rready  input  1  read data accepted by the master.
- awaddr  input  32  write byte address.
- awvalid  input  1  write address valid.
- awready  output  1  write address accepted.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  input  1  write data valid.
- wready  output  1  write data accepted.
- bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  output  1  write response valid.
- bready  input  1  write response accepted by the master.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Drives rvalid=0, bvalid=0, rdata=0, bresp=0, arready=0, awready=0, wready=0.
  - Clears every FSM, counter and held address/data.
  - Array contents are preserved.
  - A pending write that has not yet committed is dropped.
  - First cycle after reset: arready=awready=wready=1.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_BITS.
  - Word index = (addr - BASE_ADDR)[ADDR_BITS+1:2]; addr[1:0] ignored.
  - Compute in 33 bits so that no out-of-range address wraps into the array.
- Read FSM states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, capture the address, load the counter with READ_LATENCY-1, and go to R_WAIT. If READ_LATENCY=1, go directly to R_RESP.
  - R_WAIT: arready=0; the counter decrements each cycle. When it reaches 0, sample the array into rdata and go to R_RESP. Out-of-range addresses sample 0.
  - R_RESP: rvalid=1; rdata holds stable until rready. On rvalid&rready, go to R_IDLE. Next-cycle arready=1, so minimum read interval is READ_LATENCY+1 cycles.
  - rvalid never depends combinationally on rready.
- Write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP:
  - awready=1 in W_IDLE and W_HAVE_D; wready=1 in W_IDLE and W_HAVE_A.
  - AW and W may arrive in either order or in the same cycle. Same cycle goes W_IDLE->W_COMMIT; otherwise the path goes via W_HAVE_A or W_HAVE_D.
  - W_COMMIT (one cycle, no readies asserted): write only the strobed bytes if in range. Set bresp=00 if in range, otherwise 10 with no array change. Go to W_RESP.
  - W_RESP: bvalid=1 and bresp held until bready; then go to W_IDLE.
  - wstrb=0 in range commits nothing but still returns OKAY.
- Read/write collision: if the read sample cycle coincides with W_COMMIT to the same word, the read returns the pre-write data.

Optional Feature:
- AXI_SRAM_RAND_WAIT_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - arready is gated with lfsr[0], and awready/wready with lfsr[1].
  - R_WAIT adds lfsr[3:2] extra cycles, latched at AR acceptance.
  - All other rules are unchanged; this exercises master back-pressure handling.
- Not defined: the LFSR is absent and the timing is exactly as above.

Test Plan:
- Read latency: write 32'hDEADBEEF, wstrb=4'hF to 32'h8000_0010, then read it with READ_LATENCY=3 and rready=1. Required: arready high at AR, rvalid exactly 3 cycles after the AR handshake, rdata=32'hDEADBEEF, bresp=00.
- Byte strobes: word 32'h1122_3344, then write wdata=32'hAABB_CCDD with wstrb=4'b0101. Required: readback 32'h11BB_33DD.
- Write ordering: W presented 2 cycles before AW. Required: wready handshake first, then AW handshake, one W_COMMIT cycle, then bvalid. Hold bready=0 for 4 cycles; required: bvalid and bresp stay stable.
- Out of range: read 32'h7FFF_FFFC gives rdata=0. Write to 32'h8004_0000 (ADDR_BITS=16) gives bresp=2'b10, and word 0 is unchanged.
- Concurrency and collision: issue a read and a write to the same word so that the sample cycle coincides with W_COMMIT. Required: the old value is returned, and a following read returns the new value.
- Reset mid-transaction: assert rst while in R_WAIT and W_HAVE_A. Required: the next cycle has rvalid=bvalid=0 and all readies=0. After release, the readies are 1 and the target word is unchanged.
